lcd_bcd_display: RTL and testbench

Parametrised HD44780-style character-LCD writer for the 8-bit bus. It runs the power-up init sequence itself and honours enable-pulse and command-execution timing with internal counters. On each start pulse it writes a latched NDIG-digit BCD reading as "<int>.<frac> °<unit>", e.g. "25.37 °C". It sits between the BCD converter and the LCD pins.

---
 rtl/lcd_bcd_display.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_bcd_display.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bcd_display.sv
// HD44780 8-bit character-LCD writer: runs its own power-up wait and init, then on each
// accepted start writes a latched BCD reading as "<int>.<frac> <deg><unit>".
module lcd_bcd_display #(
  parameter int NDIG         = 4,
  parameter int FRAC_DIG     = 2,
  parameter int BLANK_LZ     = 0,
  parameter int EN_PULSE_CYC = 12,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int POR_WAIT_CYC = 750000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd,
  input  logic [7:0]        unit,
  output logic              busy,
  output logic              done,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic [7:0]        lcd_data
);

  localparam int NINT  = NDIG - FRAC_DIG;
  localparam int NCHAR = NDIG + ((FRAC_DIG > 0) ? 1 : 0) + 3;
  localparam int MAX_A = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_B = (CLR_WAIT_CYC > POR_WAIT_CYC) ? CLR_WAIT_CYC : POR_WAIT_CYC;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXC + 1);

  localparam logic [CW-1:0] EN_LAST  = CW'(EN_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);
  localparam logic [CW-1:0] POR_LAST = CW'(POR_WAIT_CYC - 1);

  typedef enum logic [2:0] {S_POR, S_INIT, S_IDLE, S_ADDR, S_CHAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t            state, state_n;
  phase_t            phase, phase_n;
  logic [CW-1:0]     cnt, cnt_n, wait_last;
  logic [3:0]        idx, idx_n;
  logic              load, accept, done_n, rs_n, blank;
  logic [7:0]        byte_n;
  logic [3:0]        nib;
  logic [4*NDIG-1:0] bcd_q;
  logic [7:0]        unit_q;
  logic [7:0]        chars [16];

  // Frame text from the latched reading; blanking stops at the first non-zero integer digit.
  always_comb begin
    for (int k = 0; k < 16; k++) chars[4'(k)] = 8'h20;
    blank = (BLANK_LZ != 0);
    nib   = 4'd0;
    for (int d = 0; d < NDIG; d++) begin
      nib = bcd_q[4*(NDIG-1-d) +: 4];
      if (d < NINT && blank && nib == 4'd0 && d != NINT - 1) begin
        chars[4'(d)] = 8'h20;
      end else begin
        if (d < NINT) blank = 1'b0;
        chars[4'((d < NINT) ? d : d + 1)] = (nib > 4'd9) ? 8'h2D : {4'h3, nib};
      end
    end
    if (FRAC_DIG > 0) chars[4'(NINT)] = 8'h2E;
    chars[4'(NCHAR-3)] = 8'h20;
    chars[4'(NCHAR-2)] = 8'hDF;
    chars[4'(NCHAR-1)] = unit_q;
  end

  // The byte on the bus decides how long the controller needs after the strobe.
  assign wait_last = (!lcd_rs && lcd_data == 8'h01) ? CLR_LAST : CMD_LAST;

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    idx_n   = idx;
    load    = 1'b0;
    accept  = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_POR: begin
        if (cnt == POR_LAST) begin
          state_n = S_INIT;
          phase_n = PH_SETUP;
          cnt_n   = '0;
          idx_n   = 4'd0;
          load    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (start && !done) begin
          accept  = 1'b1;
          state_n = S_ADDR;
          phase_n = PH_SETUP;
          cnt_n   = '0;
          load    = 1'b1;
        end
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_n = PH_PULSE;
            cnt_n   = '0;
          end
          PH_PULSE: begin
            if (cnt == EN_LAST) begin
              phase_n = PH_WAIT;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          default: begin
            if (cnt == wait_last) begin
              cnt_n   = '0;
              phase_n = PH_SETUP;
              load    = 1'b1;
              if (state == S_INIT && idx == 4'd3) begin
                state_n = S_IDLE;
                phase_n = PH_WAIT;
                load    = 1'b0;
              end else if (state == S_ADDR) begin
                state_n = S_CHAR;
                idx_n   = 4'd0;
              end else if (state == S_CHAR && idx == 4'(NCHAR - 1)) begin
                state_n = S_IDLE;
                phase_n = PH_WAIT;
                load    = 1'b0;
                done_n  = 1'b1;
              end else begin
                idx_n = idx + 4'd1;
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    byte_n = 8'h00;
    rs_n   = 1'b0;
    case (state_n)
      S_INIT: begin
        case (idx_n)
          4'd0:    byte_n = 8'h38;
          4'd1:    byte_n = 8'h0C;
          4'd2:    byte_n = 8'h06;
          default: byte_n = 8'h01;
        endcase
      end
      S_ADDR: byte_n = 8'h80;
      S_CHAR: begin
        byte_n = chars[idx_n];
        rs_n   = 1'b1;
      end
      default: byte_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_POR;
      phase    <= PH_WAIT;
      cnt      <= '0;
      idx      <= 4'd0;
      bcd_q    <= '0;
      unit_q   <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      lcd_en <= (phase_n == PH_PULSE);
      done   <= done_n;
      if (load) begin
        lcd_rs   <= rs_n;
        lcd_data <= byte_n;
      end
      if (accept) begin
        bcd_q  <= bcd;
        unit_q <= unit;
      end
    end
  end

  assign busy   = (state != S_IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bcd_display.sv
// Bench for lcd_bcd_display: two instances (with and without a decimal point), scoreboard of
// expected bus writes and done pulses, plus strobe-width and wait-gap timing checks.
module tb_lcd_bcd_display;
  localparam int EN   = 2;
  localparam int CMDW = 4;
  localparam int CLRW = 10;
  localparam int PORW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [15:0] bcd [2];
  logic [7:0]  unit [2];
  logic [7:0]  lcd_data [2];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [9:0] exp_q0 [$];
  logic [9:0] exp_q1 [$];

  always #5 clk = ~clk;

  lcd_bcd_display #(.NDIG(4), .FRAC_DIG(2), .BLANK_LZ(1), .EN_PULSE_CYC(EN),
    .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW), .POR_WAIT_CYC(PORW)) u_frac (
    .clk(clk), .rst(rst), .start(start[0]), .bcd(bcd[0]), .unit(unit[0]),
    .busy(busy[0]), .done(done[0]), .lcd_rs(lcd_rs[0]), .lcd_rw(lcd_rw[0]),
    .lcd_en(lcd_en[0]), .lcd_data(lcd_data[0]));

  lcd_bcd_display #(.NDIG(4), .FRAC_DIG(0), .BLANK_LZ(1), .EN_PULSE_CYC(EN),
    .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW), .POR_WAIT_CYC(PORW)) u_int (
    .clk(clk), .rst(rst), .start(start[1]), .bcd(bcd[1]), .unit(unit[1]),
    .busy(busy[1]), .done(done[1]), .lcd_rs(lcd_rs[1]), .lcd_rw(lcd_rw[1]),
    .lcd_en(lcd_en[1]), .lcd_data(lcd_data[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [9:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic sb_cmp(input int i, input logic [9:0] got);
    logic [9:0] e;
    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
      chk((i == 0) ? "sb0_unexpected" : "sb1_unexpected", {22'h0, got}, 32'hFFFF_FFFF);
    end else begin
      if (i == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      chk((i == 0) ? "sb0_write" : "sb1_write", {22'h0, got}, {22'h0, e});
    end
  endtask

  task automatic push_init(input int i);
    push(i, 10'h038); push(i, 10'h00C); push(i, 10'h006); push(i, 10'h001);
  endtask

  // Reference text model; both instances blank leading zeros.
  task automatic push_frame(input int i, input logic [15:0] v, input logic [7:0] u, input int frac);
    bit blanking;
    int nint;
    logic [3:0] n;
    blanking = 1'b1;
    nint = 4 - frac;
    push(i, 10'h080);
    for (int d = 0; d < 4; d++) begin
      n = v[4*(3-d) +: 4];
      if (frac > 0 && d == nint) push(i, 10'h12E);
      if (d < nint && blanking && n == 4'd0 && d != nint - 1) begin
        push(i, 10'h120);
      end else begin
        if (d < nint) blanking = 1'b0;
        push(i, (n > 4'd9) ? 10'h12D : {2'b01, 4'h3, n});
      end
    end
    push(i, 10'h120); push(i, 10'h1DF); push(i, {2'b01, u}); push(i, 10'h200);
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d == 8'h01) ? CLRW : CMDW;
  endfunction

  int         hi_len [2];
  int         gap [2];
  bit         inflight [2];
  bit         en_prev [2];
  logic       last_rs [2];
  logic [7:0] last_byte [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        en_prev[i]  = 1'b0;
        inflight[i] = 1'b0;
        hi_len[i]   = 0;
      end else begin
        if (lcd_en[i] && !en_prev[i]) begin
          if (inflight[i]) chk("wait_gap", gap[i], wait_of(last_rs[i], last_byte[i]) + 1);
          sb_cmp(i, {1'b0, lcd_rs[i], lcd_data[i]});
          hi_len[i]   = 1;
          inflight[i] = 1'b0;
        end else if (lcd_en[i]) begin
          hi_len[i]++;
        end else if (en_prev[i]) begin
          chk("en_width", hi_len[i], EN);
          inflight[i]  = 1'b1;
          gap[i]       = 1;
          last_rs[i]   = lcd_rs[i];
          last_byte[i] = lcd_data[i];
        end else if (inflight[i]) begin
          if (!busy[i]) begin
            chk("tail_wait", gap[i], wait_of(last_rs[i], last_byte[i]));
            inflight[i] = 1'b0;
          end else begin
            gap[i]++;
          end
        end
        if (done[i]) begin
          sb_cmp(i, {done[i], 9'h000});
          chk("done_idle", busy[i], 0);
          if (i == 0) done_cnt++;
        end
        en_prev[i] = lcd_en[i];
      end
    end
  end

  task automatic wait_idle(input int i, input int lim);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy[i] && n < lim);
    chk("idle_timeout", busy[i], 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic por_check();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!lcd_en[0] && n < 50);
    chk("por_len", n, PORW + 1);
  endtask

  task automatic run_frame(input int i, input logic [15:0] v, input logic [7:0] u, input int frac);
    bcd[i]  = v;
    unit[i] = u;
    push_frame(i, v, u, frac);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    rst = 1'b1; start = 2'b00;
    bcd[0] = 16'h0; bcd[1] = 16'h0; unit[0] = 8'h0; unit[1] = 8'h0;
    push_init(0); push_init(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy[0], 1);
    chk("rst_en", lcd_en[0], 0);
    chk("rst_data", lcd_data[0], 8'h00);
    chk("rst_rs", lcd_rs[0], 0);
    chk("rst_rw", lcd_rw, 2'b00);
    chk("rst_done", done[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    por_check();
    wait_idle(0, 200);
    wait_idle(1, 200);

    // Nominal frame with latency check
    run_frame(0, 16'h2537, 8'h43, 2);
    chk("busy_after_start", busy[0], 1);
    n = 1;
    while (!done[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_len", n, 9 * (1 + EN + CMDW) + 1);
    wait_idle(0, 200);

    run_frame(0, 16'h0042, 8'h46, 2);
    wait_idle(0, 200);
    run_frame(1, 16'h0000, 8'h43, 0);
    wait_idle(1, 200);
    run_frame(0, 16'h1A05, 8'h43, 2);
    wait_idle(0, 200);
    run_frame(0, 16'h0A12, 8'h4B, 2);
    wait_idle(0, 200);

    // Start and input changes mid-frame are ignored
    d0 = done_cnt;
    run_frame(0, 16'h9876, 8'h4B, 2);
    repeat (21) @(posedge clk);
    #1;
    start[0] = 1'b1; bcd[0] = 16'h1111; unit[0] = 8'h58;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_idle(0, 200);
    repeat (30) @(posedge clk);
    #1;
    chk("single_done", done_cnt - d0, 1);

    // Start held high gives back-to-back frames
    bcd[0] = 16'h0310; unit[0] = 8'h43;
    push_frame(0, 16'h0310, 8'h43, 2);
    push_frame(0, 16'h0310, 8'h43, 2);
    start[0] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done[0] && n < 200);
    @(posedge clk);
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("b2b_busy", busy[0], 1);
    wait_idle(0, 200);

    // Reset during a character strobe
    run_frame(0, 16'h2537, 8'h43, 2);
    n = 0;
    while (!(lcd_rs[0] && lcd_en[0]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_en", lcd_en[0], 0);
    chk("arst_data", lcd_data[0], 8'h00);
    chk("arst_busy", busy[0], 1);
    chk("arst_rs", lcd_rs[0], 0);
    exp_q0.delete(); exp_q1.delete();
    push_init(0); push_init(1);
    @(posedge clk); #1;
    rst = 1'b0;
    por_check();
    wait_idle(0, 200);
    wait_idle(1, 200);

    chk("drain0", exp_q0.size(), 0);
    chk("drain1", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
